// File: rtl/hsv_core_pkg.sv
// rtl/hsv_core_pkg.sv - shared types and constants for the hsv core commit path
package hsv_core_pkg;

    localparam int COMMIT_TAG_W = 4;
    localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

    typedef logic [COMMIT_TAG_W-1:0] commit_tag;

    typedef struct packed {
        logic [31:0] pc;
        commit_tag   tag;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        writeback;
        logic        jump;
        logic [31:0] next_pc;
        logic        trap;
    } commit_data_t;

    typedef enum logic [1:0] {
        COMMIT_RUN,
        COMMIT_FLUSH,
        COMMIT_REDIRECT
    } commit_state_t;

endpackage

// File: rtl/hsv_core_commit_select.sv
// rtl/hsv_core_commit_select.sv - tag matcher and lowest-index priority grant
module hsv_core_commit_select
    import hsv_core_pkg::*;
#(
    parameter int NUM_UNITS = 2
) (
    input  commit_data_t [NUM_UNITS-1:0] commit_data,
    input  logic [NUM_UNITS-1:0]         valid,
    input  commit_tag                    next_tag,
    output logic [NUM_UNITS-1:0]         match,
    output logic [NUM_UNITS-1:0]         grant,
    output commit_data_t                 sel_data
);

    always_comb begin
        match    = '0;
        grant    = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            match[i] = valid[i] && (commit_data[i].tag == next_tag);
        end
        // Ascending scan with an empty-grant guard keeps the lowest index.
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (match[i] && (grant == '0)) begin
                grant[i] = 1'b1;
                sel_data = commit_data[i];
            end
        end
    end

endmodule

// File: rtl/hsv_core_commit.sv
// rtl/hsv_core_commit.sv - in-order commit stage with flush and redirect control
module hsv_core_commit
    import hsv_core_pkg::*;
#(
    parameter int          NUM_UNITS   = 2,
    parameter int          TAG_W       = COMMIT_TAG_W,
    parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
) (
    input  logic                         clk_core,
    input  logic                         rst_core,
    input  commit_data_t [NUM_UNITS-1:0] in_commit_data,
    input  logic [NUM_UNITS-1:0]         in_valid,
    output logic [NUM_UNITS-1:0]         in_ready,
    input  logic [NUM_UNITS-1:0]         flush_ack,
    output logic                         flush_req,
    output logic                         wr_en,
    output logic [4:0]                   wr_rd,
    output logic [31:0]                  wr_value,
    output logic                         retire_valid,
    output logic [TAG_W-1:0]             retire_tag,
    output logic                         redirect_valid,
    output logic [31:0]                  redirect_pc
);

    commit_state_t          state;
    logic [TAG_W-1:0]       next_tag;
    logic [NUM_UNITS-1:0]   match;
    logic [NUM_UNITS-1:0]   grant;
    commit_data_t           sel_data;
    logic                   handshake;
    logic                   commit_unused;

    hsv_core_commit_select #(
        .NUM_UNITS (NUM_UNITS)
    ) u_select (
        .commit_data (in_commit_data),
        .valid       (in_valid),
        .next_tag    (next_tag),
        .match       (match),
        .grant       (grant),
        .sel_data    (sel_data)
    );

    assign in_ready      = (state == COMMIT_RUN && !rst_core) ? grant : '0;
    assign handshake     = |in_ready;
    assign commit_unused = &{1'b0, sel_data.pc};

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state          <= COMMIT_RUN;
            next_tag       <= '0;
            flush_req      <= 1'b0;
            wr_en          <= 1'b0;
            wr_rd          <= '0;
            wr_value       <= '0;
            retire_valid   <= 1'b0;
            retire_tag     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            wr_en          <= 1'b0;
            retire_valid   <= 1'b0;
            redirect_valid <= 1'b0;
            case (state)
                COMMIT_RUN: begin
                    if (handshake) begin
                        retire_valid <= 1'b1;
                        retire_tag   <= sel_data.tag;
                        wr_en        <= sel_data.writeback && (sel_data.rd != 5'd0) && !sel_data.trap;
                        wr_rd        <= sel_data.rd;
                        wr_value     <= sel_data.result;
                        next_tag     <= next_tag + 1'b1;
                        if (sel_data.jump || sel_data.trap) begin
                            state       <= COMMIT_FLUSH;
                            flush_req   <= 1'b1;
                            redirect_pc <= sel_data.trap ? TRAP_VECTOR : sel_data.next_pc;
                        end
                    end
                end
                COMMIT_FLUSH: begin
                    // Acks must all be high together; a stale earlier ack does not count.
                    if (&flush_ack) begin
                        state          <= COMMIT_REDIRECT;
                        flush_req      <= 1'b0;
                        redirect_valid <= 1'b1;
                        next_tag       <= '0;
                    end
                end
                COMMIT_REDIRECT: begin
                    state <= COMMIT_RUN;
                end
                default: begin
                    state <= COMMIT_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk_core) begin
        if (!rst_core && state == COMMIT_RUN) begin
            assert ($onehot0(match));
        end
    end

endmodule

// File: tb/tb_hsv_core_commit.sv
// tb/tb_hsv_core_commit.sv - directed self-checking bench for hsv_core_commit
module tb_hsv_core_commit;
    import hsv_core_pkg::*;

    logic               clk_core = 1'b0;
    logic               rst_core;
    commit_data_t [1:0] in_commit_data;
    logic [1:0]         in_valid;
    logic [1:0]         in_ready;
    logic [1:0]         flush_ack;
    logic               flush_req;
    logic               wr_en;
    logic [4:0]         wr_rd;
    logic [31:0]        wr_value;
    logic               retire_valid;
    logic [3:0]         retire_tag;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_core = ~clk_core;

    hsv_core_commit #(
        .NUM_UNITS   (2),
        .TAG_W       (4),
        .TRAP_VECTOR (32'h0000_0100)
    ) dut (
        .clk_core       (clk_core),
        .rst_core       (rst_core),
        .in_commit_data (in_commit_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .flush_ack      (flush_ack),
        .flush_req      (flush_req),
        .wr_en          (wr_en),
        .wr_rd          (wr_rd),
        .wr_value       (wr_value),
        .retire_valid   (retire_valid),
        .retire_tag     (retire_tag),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic commit_data_t mk(input logic [3:0] tag, input logic [4:0] rd,
                                        input logic [31:0] result, input logic wb,
                                        input logic jump, input logic trap,
                                        input logic [31:0] npc);
        commit_data_t d;
        d           = '0;
        d.pc        = 32'h0000_1000;
        d.tag       = tag;
        d.rd        = rd;
        d.result    = result;
        d.writeback = wb;
        d.jump      = jump;
        d.trap      = trap;
        d.next_pc   = npc;
        return d;
    endfunction

    task automatic tick();
        @(negedge clk_core);
    endtask

    initial begin
        rst_core       = 1'b1;
        in_valid       = '0;
        flush_ack      = '0;
        in_commit_data = '0;
        tick();
        tick();
        check("rst_flush_req", {31'd0, flush_req}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_retire_valid", {31'd0, retire_valid}, 32'd0);
        check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_wr_rd", {27'd0, wr_rd}, 32'd0);
        check("rst_wr_value", wr_value, 32'd0);
        check("rst_retire_tag", {28'd0, retire_tag}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);

        // Matching handshake offered during reset must not retire
        in_commit_data[0] = mk(4'd0, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 32'd0);
        in_valid          = 2'b01;
        #1 check("rst_in_ready", {30'd0, in_ready}, 32'd0);
        tick();
        check("rst_no_retire", {31'd0, retire_valid}, 32'd0);

        // Single ALU retire
        rst_core = 1'b0;
        #1 check("alu_in_ready", {30'd0, in_ready}, 32'd1);
        tick();
        in_valid = 2'b00;
        check("alu_retire_valid", {31'd0, retire_valid}, 32'd1);
        check("alu_wr_en", {31'd0, wr_en}, 32'd1);
        check("alu_wr_rd", {27'd0, wr_rd}, 32'd5);
        check("alu_wr_value", wr_value, 32'h1234);
        check("alu_retire_tag", {28'd0, retire_tag}, 32'd0);
        tick();
        check("alu_wr_en_pulse", {31'd0, wr_en}, 32'd0);
        check("alu_retire_pulse", {31'd0, retire_valid}, 32'd0);

        // Out-of-order arrival: unit1 tag 2 waits for unit0 tag 1
        in_commit_data[0] = mk(4'd1, 5'd6, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0, 32'd0);
        in_commit_data[1] = mk(4'd2, 5'd7, 32'hBBBB_0002, 1'b1, 1'b0, 1'b0, 32'd0);
        in_valid          = 2'b11;
        #1 check("ooo_in_ready_first", {30'd0, in_ready}, 32'd1);
        tick();
        in_valid = 2'b10;
        check("ooo_tag_first", {28'd0, retire_tag}, 32'd1);
        check("ooo_value_first", wr_value, 32'hAAAA_0001);
        #1 check("ooo_in_ready_second", {30'd0, in_ready}, 32'd2);
        tick();
        in_valid = 2'b00;
        check("ooo_tag_second", {28'd0, retire_tag}, 32'd2);
        check("ooo_rd_second", {27'd0, wr_rd}, 32'd7);
        check("ooo_retire_second", {31'd0, retire_valid}, 32'd1);

        // rd=0 suppresses the write but still retires
        in_commit_data[0] = mk(4'd3, 5'd0, 32'hDEAD, 1'b1, 1'b0, 1'b0, 32'd0);
        in_valid          = 2'b01;
        tick();
        in_valid = 2'b00;
        check("rd0_retire_valid", {31'd0, retire_valid}, 32'd1);
        check("rd0_wr_en", {31'd0, wr_en}, 32'd0);

        // Non-matching input is held
        in_commit_data[1] = mk(4'd5, 5'd9, 32'h55, 1'b1, 1'b0, 1'b0, 32'd0);
        in_valid          = 2'b10;
        #1 check("hold_in_ready", {30'd0, in_ready}, 32'd0);
        tick();
        check("hold_no_retire", {31'd0, retire_valid}, 32'd0);

        // Jump with link writeback, then flush with staggered acks
        in_commit_data[0] = mk(4'd4, 5'd1, 32'h0000_1004, 1'b1, 1'b1, 1'b0, 32'h80);
        in_valid          = 2'b11;
        #1 check("jmp_in_ready", {30'd0, in_ready}, 32'd1);
        tick();
        in_valid = 2'b10;
        check("jmp_retire", {31'd0, retire_valid}, 32'd1);
        check("jmp_link_wr_en", {31'd0, wr_en}, 32'd1);
        check("jmp_link_rd", {27'd0, wr_rd}, 32'd1);
        check("jmp_flush_req_p1", {31'd0, flush_req}, 32'd1);
        #1 check("flush_in_ready_blocked", {30'd0, in_ready}, 32'd0);
        tick();
        flush_ack = 2'b01;
        check("jmp_flush_req_p2", {31'd0, flush_req}, 32'd1);
        check("flush_no_retire", {31'd0, retire_valid}, 32'd0);
        tick();
        flush_ack = 2'b10;
        check("jmp_flush_req_p3", {31'd0, flush_req}, 32'd1);
        check("flush_no_accumulate", {31'd0, redirect_valid}, 32'd0);
        tick();
        flush_ack = 2'b11;
        check("jmp_flush_req_p4", {31'd0, flush_req}, 32'd1);
        check("jmp_no_redirect_yet", {31'd0, redirect_valid}, 32'd0);
        tick();
        flush_ack = 2'b00;
        check("jmp_flush_req_drop", {31'd0, flush_req}, 32'd0);
        check("jmp_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("jmp_redirect_pc", redirect_pc, 32'h80);
        check("redirect_no_retire", {31'd0, retire_valid}, 32'd0);
        tick();
        check("jmp_redirect_pulse", {31'd0, redirect_valid}, 32'd0);
        #1 check("post_redirect_tag5_held", {30'd0, in_ready}, 32'd0);
        in_commit_data[1] = mk(4'd0, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0, 32'd0);
        #1 check("post_redirect_tag0_ready", {30'd0, in_ready}, 32'd2);
        tick();
        in_valid = 2'b00;
        check("post_redirect_tag", {28'd0, retire_tag}, 32'd0);
        check("post_redirect_retire", {31'd0, retire_valid}, 32'd1);

        // Trap: write suppressed, redirect to the trap vector
        in_commit_data[0] = mk(4'd1, 5'd3, 32'h33, 1'b1, 1'b0, 1'b1, 32'h400);
        in_valid          = 2'b01;
        tick();
        in_valid  = 2'b00;
        flush_ack = 2'b11;
        check("trap_retire", {31'd0, retire_valid}, 32'd1);
        check("trap_wr_en", {31'd0, wr_en}, 32'd0);
        check("trap_flush_req", {31'd0, flush_req}, 32'd1);
        tick();
        flush_ack = 2'b00;
        check("trap_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("trap_redirect_pc", redirect_pc, 32'h100);
        tick();

        // Tag wrap: 17 back-to-back retires from tag 0
        in_valid = 2'b01;
        for (int i = 0; i < 17; i++) begin
            in_commit_data[0] = mk(4'(i % 16), 5'(i % 31 + 1), 32'(i), 1'b1, 1'b0, 1'b0, 32'd0);
            #1 check($sformatf("wrap_ready_%0d", i), {30'd0, in_ready}, 32'd1);
            tick();
            check($sformatf("wrap_tag_%0d", i), {28'd0, retire_tag}, 32'(i % 16));
            check($sformatf("wrap_retire_%0d", i), {31'd0, retire_valid}, 32'd1);
        end
        in_valid = 2'b00;

        // Reset asserted during FLUSH abandons the redirect
        in_commit_data[0] = mk(4'd1, 5'd4, 32'h44, 1'b0, 1'b1, 1'b0, 32'h200);
        in_valid          = 2'b01;
        tick();
        in_valid = 2'b00;
        check("rstflush_flush_req", {31'd0, flush_req}, 32'd1);
        rst_core = 1'b1;
        tick();
        rst_core  = 1'b0;
        flush_ack = 2'b11;
        check("rstflush_flush_req_drop", {31'd0, flush_req}, 32'd0);
        check("rstflush_redirect_pc", redirect_pc, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rstflush_no_redirect_%0d", i), {31'd0, redirect_valid}, 32'd0);
        end
        flush_ack         = 2'b00;
        in_commit_data[0] = mk(4'd0, 5'd8, 32'h88, 1'b1, 1'b0, 1'b0, 32'd0);
        in_valid          = 2'b01;
        #1 check("rstflush_tag0_ready", {30'd0, in_ready}, 32'd1);
        tick();
        in_valid = 2'b00;
        check("rstflush_retire_tag", {28'd0, retire_tag}, 32'd0);
        check("rstflush_wr_value", wr_value, 32'h88);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hsv_core_commit.md
Name: hsv_core_commit

Overview:
- In-order commit stage downstream of the ALU and the other execution units.
- Accepts commit_data_t from NUM_UNITS handshake channels and retires results strictly in issue order, using a sequence tag.
- Writes the register file and drives the global flush_req/flush_ack protocol.
- Issues a PC redirect on jumps and traps.

Parameters:
- NUM_UNITS, 2, number of execution-unit commit channels (index 0 = ALU).
- TAG_W, 4, width of the issue sequence tag; tags wrap modulo 2^TAG_W.
- TRAP_VECTOR, 32'h0000_0100, redirect PC used when a trap retires.

Ports:
- clk_core  in  1  core clock
- rst_core  in  1  reset
- in_commit_data  in  NUM_UNITS x $bits(commit_data_t)  per-unit commit payload
- in_valid  in  NUM_UNITS  per-unit payload valid
- in_ready  out  NUM_UNITS  per-unit accept
- flush_ack  in  NUM_UNITS  per-unit flush completion
- flush_req  out  1  global flush request to all units
- wr_en  out  1  register-file write enable
- wr_rd  out  5  register-file destination index
- wr_value  out  32  register-file write data
- retire_valid  out  1  one instruction retired this cycle
- retire_tag  out  TAG_W  tag of the retired instruction, for scoreboard release
- redirect_valid  out  1  fetch redirect pulse
- redirect_pc  out  32  fetch redirect target

Interface note: one clock, clk_core. rst_core is synchronous and active-high.

Behaviour:
- Reset values:
  - next_tag=0, state=RUN.
  - flush_req, wr_en, retire_valid and redirect_valid are 0.
  - wr_rd, wr_value, retire_tag and redirect_pc are 0.
  - in_ready is all 0.
- commit_data_t fields used: pc, tag, rd, result, writeback, jump, next_pc, trap.
- Selection (RUN only):
  - Unit i matches when in_valid[i] && tag==next_tag.
  - The lowest-index match wins. More than one match is an assertion failure.
  - in_ready[i]=1 only for the winning unit.
  - in_ready is combinational from in_valid/tag/state, with no dependency on the outputs.
- At most one retirement per cycle.
- Handshake at cycle N (in_valid & in_ready) produces registered outputs at N+1:
  - retire_valid=1 and retire_tag=tag.
  - wr_en=1 only if writeback && rd!=0 && !trap; wr_rd=rd; wr_value=result.
  - next_tag increments with wrap: 2^TAG_W-1 goes to 0.
- A non-matching valid input is held: it is not accepted, and the unit keeps in_valid and its payload stable.
- If the retired entry has jump or trap, the state goes to FLUSH at N+1.
  - redirect_pc is latched: TRAP_VECTOR if trap, else next_pc.
  - A jump with writeback still writes rd (link register).
- FLUSH:
  - flush_req=1 and in_ready all 0.
  - Waits until flush_ack is all-ones in the same cycle; acks are not accumulated across cycles.
  - Then goes to REDIRECT on the next cycle.
- REDIRECT:
  - flush_req=0, redirect_valid=1 for exactly one cycle, next_tag is reset to 0, then back to RUN.
  - Issue restarts tags at 0 after a redirect.
- Outputs wr_en, retire_valid and redirect_valid are single-cycle pulses. They are 0 in any cycle without the corresponding event.
- rst_core asserted in any state:
  - Next state is RUN with reset values; a pending flush is abandoned.
  - A handshake presented in the reset cycle is not retired.
- No retirement occurs while in FLUSH or REDIRECT, even if a matching tag is valid.

Decomposition:
- hsv_core_pkg additions:
  - Extend commit_data_t with tag, rd, result, writeback, jump, next_pc and trap.
  - Add typedef commit_tag (logic [TAG_W-1:0]) and enum commit_state_t {COMMIT_RUN, COMMIT_FLUSH, COMMIT_REDIRECT}.
  - Add constant TRAP_VECTOR_DEFAULT.
- Sub-module hsv_core_commit_select: combinational tag matcher plus priority encoder, producing a one-hot grant and the selected payload.

Test Plan:
- Single ALU retire: unit0 tag=0, rd=5, result=32'h1234, writeback=1 -> next cycle wr_en=1, wr_rd=5, wr_value=32'h1234, retire_tag=0; next_tag=1.
- Out-of-order arrival: unit1 tag=1 and unit0 tag=0 both valid in the same cycle -> unit0 accepted first and unit1 on the next cycle; retire_tag sequence 0,1; unit1's in_ready stays 0 while tag 1 is not yet expected.
- rd=0 and trap suppression: rd=0 with writeback=1 -> retire_valid=1, wr_en=0. trap=1, rd=3 -> wr_en=0 and FLUSH entered.
- Jump flush:
  - Stimulus: retire with jump=1, next_pc=32'h80; flush_ack raised by unit0 at +2 and by unit1 at +4.
  - Response: flush_req high from +1 through the all-ack cycle; redirect_valid for one cycle with redirect_pc=32'h80; next_tag=0.
- Tag wrap: retire 17 sequential instructions with TAG_W=4 -> retire_tag runs 0..15,0 and no stall at the wrap.
- Reset mid-flush: assert rst_core during FLUSH -> the following cycle has flush_req=0, redirect_valid never pulses, state RUN, next_tag=0.
